// File: rtl/coreport_debounce.sv
// coreport_debounce: per-pin synchroniser and debounce filter ahead of the GPIO port input path.
// Optional feature macro: COREPORT_DEBOUNCE_EDGE_EN enables the registered rise/fall pulse outputs.
`default_nettype none

module coreport_debounce #(
  parameter int              WIDTH         = 8,
  parameter int              PRESCALE      = 4,
  parameter int              DEPTH         = 3,
  parameter logic [WIDTH-1:0] INITIAL_LEVEL = '0
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] en_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!en_i[i]) begin
        out_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else if (tick) begin
        if (s2_q[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // DEPTH consecutive mismatching ticks seen: accept the new level
          out_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      pre_q <= '0;
      s1_q  <= INITIAL_LEVEL;
      s2_q  <= INITIAL_LEVEL;
      out_q <= INITIAL_LEVEL;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      pre_q <= pre_d;
      s1_q  <= pin_i;
      s2_q  <= s1_q;
      out_q <= out_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_o = out_q;

`ifdef COREPORT_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Pulses are computed from the same next-state as out_q, so they align with the out_o change
  always_comb begin
    rise_d = ~out_q & out_d;
    fall_d = out_q & ~out_d;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coreport_debounce.sv
// Scoreboarded bench for coreport_debounce: behavioural model pushes expected outputs, a monitor pops and compares.
`default_nettype none

module tb_coreport_debounce;

  localparam int         W     = 8;
  localparam int         PRE   = 4;
  localparam int         DEP   = 3;
  localparam logic [7:0] INIT  = 8'h00;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pin = '0;
  logic [W-1:0] en  = '0;
  logic [W-1:0] out_o, rise_o, fall_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t exp_q[$];

  coreport_debounce #(
    .WIDTH(W), .PRESCALE(PRE), .DEPTH(DEP), .INITIAL_LEVEL(INIT)
  ) dut (
    .wb_clk(clk), .wb_rst(rst), .pin_i(pin), .en_i(en),
    .out_o(out_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: pins arrive two edges late; a sample happens on every PRE-th edge since
  // reset; a bit adopts a new level once it has disagreed on DEP samples in a row.
  logic [W-1:0] m_out;
  logic [W-1:0] pin_hist[$];
  int           m_run[W];
  int           m_edges;

  initial begin
    forever begin
      logic [W-1:0] seen, nxt;
      bit           smp;
      exp_t         e;
      @(posedge clk);
      if (rst) begin
        m_out    = INIT;
        pin_hist = '{INIT, INIT};
        m_edges  = 0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        e.out = INIT; e.rise = '0; e.fall = '0;
      end else begin
        seen = pin_hist[0];
        smp  = ((m_edges % PRE) == PRE - 1);
        nxt  = m_out;
        for (int i = 0; i < W; i++) begin
          if (!en[i]) begin
            nxt[i]   = seen[i];
            m_run[i] = 0;
          end else if (smp) begin
            if (seen[i] == m_out[i]) m_run[i] = 0;
            else begin
              m_run[i]++;
              if (m_run[i] >= DEP) begin
                nxt[i]   = seen[i];
                m_run[i] = 0;
              end
            end
          end
        end
        e.out = nxt;
`ifdef COREPORT_DEBOUNCE_EDGE_EN
        e.rise = ~m_out & nxt;
        e.fall = m_out & ~nxt;
`else
        e.rise = '0;
        e.fall = '0;
`endif
        m_out = nxt;
        void'(pin_hist.pop_front());
        pin_hist.push_back(pin);
        m_edges++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (out_o !== e.out || rise_o !== e.rise || fall_o !== e.fall) begin
          errors++;
          $display("FAIL outputs at %0t: got out=%h rise=%h fall=%h, expected out=%h rise=%h fall=%h",
                   $time, out_o, rise_o, fall_o, e.out, e.rise, e.fall);
        end
      end
    end
  end

  task automatic wait_for(input logic [W-1:0] mask, input logic [W-1:0] val,
                          input int limit, output int n);
    n = 0;
    while (((out_o & mask) !== val) && n <= limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  glitch_seen;

    // Reset / settle
    pin = 8'hFF;
    en  = 8'hFF;
    idle(4);
    checks++;
    if (out_o !== 8'h00 || rise_o !== 8'h00 || fall_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got out=%h rise=%h fall=%h, required 00 00 00", out_o, rise_o, fall_o);
    end
    rst = 1'b0;
    wait_for(8'hFF, 8'hFF, 20, lat);
    check_range("settle_latency", lat, 1, 15);
    idle(5);

    // Glitch reject on bit 0
    pin = 8'h00;
    idle(25);
    glitch_seen = 1'b0;
    pin[0] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_o[0] || rise_o[0]) glitch_seen = 1'b1;
    end
    pin[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_o[0] || rise_o[0]) glitch_seen = 1'b1;
    end
    checks++;
    if (glitch_seen) begin
      errors++;
      $display("FAIL glitch_reject: got out_o[0]/rise_o[0] high, required low");
    end

    // Fall accept on bit 3
    pin = 8'hFF;
    idle(25);
    pin[3] = 1'b0;
    wait_for(8'hFF, 8'hF7, 20, lat);
    check_range("fall_latency", lat, 11, 15);
    idle(20);

    // Bypass on bit 0
    en  = 8'h01;
    pin = 8'h00;
    idle(6);
    for (int k = 0; k < 12; k++) begin
      pin[0] = ~pin[0];
      idle(2);
    end
    idle(6);

    // Reset mid-count on bit 5
    en  = 8'hFF;
    pin = 8'h00;
    idle(25);
    pin[5] = 1'b1;
    idle(10);
    checks++;
    if (out_o[5] !== 1'b0) begin
      errors++;
      $display("FAIL midcount_before_reset: got out_o[5]=%b, required 0", out_o[5]);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wait_for(8'h20, 8'h20, 20, lat);
    check_range("midcount_restart_latency", lat, 12, 12);
    idle(5);

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 99) == 0) en = W'($urandom);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 15) == 0) pin[i] = ~pin[i];
    end
    rst = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
